vga_timing_gen: RTL and testbench

Pixel-timing generator that sits directly upstream of `VGA_Draw`. It produces the 640x480@60 Hz raster counters and the per-pixel request coordinates that `VGA_Draw` uses to look up colour. It also produces HSYNC, VSYNC and BLANK_N, delayed so they stay aligned with `VGA_Draw`'s colour latency. It runs at the 25 MHz pixel rate (40 ns period), or from a faster clock through a clock enable.

---
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, active-area pixel requests and latency-matched sync/blank
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE     = 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iCE,
  output logic       oREQ,
  output logic [9:0] oREQ_X,
  output logic [9:0] oREQ_Y,
  output logic       oLINE_START,
  output logic       oFRAME_START,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] h, v;
  logic       h_last, v_last, act, hs_raw, vs_raw;
  logic [2:0] s1, tap;
  // region decode of the current counter position
  always_comb begin
    h_last = h == H_LAST;
    v_last = v == V_LAST;
    act    = (h < HA) && (v < VA);
    hs_raw = (h >= HS_BEG) && (h < HS_END);
    vs_raw = (v >= VS_BEG) && (v < VS_END);
  end
  // raster counters: h wraps each line, v advances on h wrap and wraps each frame
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      h <= '0;
      v <= '0;
    end else if (iCE) begin
      h <= h_last ? '0 : h + 10'd1;
      if (h_last) v <= v_last ? '0 : v + 10'd1;
    end
  end
  // stage 1: request outputs plus raw sync/active bits (1 = asserted/active)
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oREQ         <= 1'b0;
      oREQ_X       <= '0;
      oREQ_Y       <= '0;
      oLINE_START  <= 1'b0;
      oFRAME_START <= 1'b0;
      s1           <= '0;
    end else if (iCE) begin
      oREQ         <= act;
      oREQ_X       <= act ? h : '0;
      oREQ_Y       <= act ? v : '0;
      oLINE_START  <= h == '0;
      oFRAME_START <= (h == '0) && (v == '0);
      s1           <= {hs_raw, vs_raw, act};
    end
  end
  if (PIPE == 0) begin : g_direct
    assign tap = s1;
  end else begin : g_pipe
    logic [2:0] sr [PIPE];
    // stage 2: PIPE-deep delay matching downstream colour latency
    always_ff @(posedge iCLK) begin
      if (iRST) begin
        for (int i = 0; i < PIPE; i++) sr[i] <= '0;
      end else if (iCE) begin
        for (int i = PIPE - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= s1;
      end
    end
    assign tap = sr[PIPE-1];
  end
  // polarity mapping of the delayed sync/blank bits
  always_comb begin
    oVGA_HS      = tap[2] ? SYNC_POL : ~SYNC_POL;
    oVGA_VS      = tap[1] ? SYNC_POL : ~SYNC_POL;
    oVGA_BLANK_N = tap[0];
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized clock-enable/reset stimulus against a pixel-index reference model
module tb_vga_timing_gen;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b1;
  logic a_req, a_ls, a_fs, a_hs, a_vs, a_bn;
  logic b_req, b_ls, b_fs, b_hs, b_vs, b_bn;
  logic c_req, c_ls, c_fs, c_hs, c_vs, c_bn;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  int n = 0, cyc = 0, ph = 0, passes = 0, total = 0, errs = 0;
  int last_ls = -1, hs_run = 0;
  logic prev_ls = 1'b0, prev_hs = 1'b1;

  always #10 clk = ~clk;

  vga_timing_gen #(.PIPE(1)) dut_a (
    .iCLK(clk), .iRST(rst), .iCE(ce), .oREQ(a_req), .oREQ_X(a_x), .oREQ_Y(a_y),
    .oLINE_START(a_ls), .oFRAME_START(a_fs), .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_BLANK_N(a_bn));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .PIPE(3)) dut_b (
    .iCLK(clk), .iRST(rst), .iCE(ce), .oREQ(b_req), .oREQ_X(b_x), .oREQ_Y(b_y),
    .oLINE_START(b_ls), .oFRAME_START(b_fs), .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_BLANK_N(b_bn));
  vga_timing_gen #(.H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(3), .V_ACTIVE(3), .V_FP(2),
    .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0), .PIPE(0)) dut_c (
    .iCLK(clk), .iRST(rst), .iCE(ce), .oREQ(c_req), .oREQ_X(c_x), .oREQ_Y(c_y),
    .oLINE_START(c_ls), .oFRAME_START(c_fs), .oVGA_HS(c_hs), .oVGA_VS(c_vs), .oVGA_BLANK_N(c_bn));

  // Outputs after n enabled edges since reset: requests describe pixel n-1, sync/blank pixel n-1-pipe.
  function automatic logic [25:0] model(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                        input bit pol, input int pipe, input int cnt);
    int ht, vt, p, q, x, y, qx, qy;
    bit rq, ls, fs, hsa, vsa, act;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p = cnt - 1;
    q = cnt - 1 - pipe;
    rq = 0; ls = 0; fs = 0; hsa = 0; vsa = 0; act = 0; x = 0; y = 0;
    if (p >= 0) begin
      x = p % ht;
      y = (p / ht) % vt;
      rq = x < ha && y < va;
      ls = x == 0;
      fs = x == 0 && y == 0;
    end
    if (q >= 0) begin
      qx = q % ht;
      qy = (q / ht) % vt;
      hsa = qx >= ha + hf && qx < ha + hf + hsw;
      vsa = qy >= va + vf && qy < va + vf + vsw;
      act = qx < ha && qy < va;
    end
    return {rq, rq ? 10'(x) : 10'd0, rq ? 10'(y) : 10'd0, ls, fs,
            hsa ? pol : !pol, vsa ? pol : !pol, act};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else begin
      errs++;
      if (errs <= 20) $display("FAIL %s at cycle %0d (n=%0d): got %h expected %h", tag, cyc, n, got, exp);
    end
  endtask

  task automatic compare_all();
    check("dut_a", 32'({a_req, a_x, a_y, a_ls, a_fs, a_hs, a_vs, a_bn}),
          32'(model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1, n)));
    check("dut_b", 32'({b_req, b_x, b_y, b_ls, b_fs, b_hs, b_vs, b_bn}),
          32'(model(8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 3, n)));
    check("dut_c", 32'({c_req, c_x, c_y, c_ls, c_fs, c_hs, c_vs, c_bn}),
          32'(model(6, 1, 2, 3, 3, 2, 1, 2, 1'b0, 0, n)));
    if (a_ls && !prev_ls && (ph == 1 || ph == 3)) begin
      if (last_ls >= 0) check("line_period", 32'(cyc - last_ls), ph == 3 ? 32'd1600 : 32'd800);
      last_ls = cyc;
    end
    if (ph == 1) begin
      if (!a_hs) hs_run++;
      if (a_hs && !prev_hs) check("hs_width", 32'(hs_run), 32'd96);
      if (a_hs) hs_run = 0;
    end
    prev_ls = a_ls;
    prev_hs = a_hs;
  endtask

  task automatic step(input bit r, input bit c);
    rst = r;
    ce = c;
    @(posedge clk);
    cyc++;
    if (r) begin
      n = 0;
      last_ls = -1;
      hs_run = 0;
    end else if (c) n++;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    check("reset_hs", 32'(a_hs), 32'd1);
    check("reset_blank", 32'(a_bn), 32'd0);
    ph = 1;
    step(1'b0, 1'b1);
    check("first_frame_start", 32'({a_fs, a_ls, a_req, a_x, a_y}), {9'd0, 3'b111, 20'd0});
    for (int i = 0; i < 999; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);
    ph = 2;
    for (int i = 0; i < 4000; i++) step(($urandom % 500) == 0, $urandom_range(0, 1) == 1);
    step(1'b1, 1'b1);
    ph = 3;
    last_ls = -1;
    for (int i = 0; i < 3400; i++) step(1'b0, i[0] == 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
